dram_bus_ctrl: RTL

//   Synthesizable master for the 4-bit-address / 8-bit-data dram chip-select bus.

---
 rtl/dram_bus_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dram_bus_ctrl.sv
// ---------------------------------------------------------------------------
// dram_bus_ctrl : FIFO-buffered csn-strobe master for the 4b-addr/8b-data dram bus.
// Optional macro DRAM_CTRL_GAP_EN adds GAP_CYCLES csn-high cycles after every access.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dram_bus_ctrl #(
  parameter int AWIDTH     = 4,
  parameter int DWIDTH     = 8,
  parameter int DEPTH      = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic              i_ck,
  input  logic              i_rstn,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_rw,
  input  logic [AWIDTH-1:0] i_req_addr,
  input  logic [DWIDTH-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DWIDTH-1:0] o_rsp_data,
  output logic              o_busy,
  output logic              o_rw,
  output logic              o_csn,
  output logic [AWIDTH-1:0] o_address,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_data_oe,
  input  logic [DWIDTH-1:0] i_data
);

  localparam int PW = $clog2(DEPTH);

`ifdef DRAM_CTRL_GAP_EN
  localparam int GAP_LEN = GAP_CYCLES;
`else
  localparam int GAP_LEN = 0 * GAP_CYCLES;  // gap disabled: GAP_CYCLES has no effect
`endif

  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              fifo_rw    [DEPTH];
  logic [AWIDTH-1:0] fifo_addr  [DEPTH];
  logic [DWIDTH-1:0] fifo_wdata [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic              full, empty, push, pop;

  logic              csn_nxt, rw_nxt, oe_nxt, rsp_valid_nxt;
  logic [AWIDTH-1:0] addr_nxt;
  logic [DWIDTH-1:0] data_nxt, rsp_data_nxt;
  logic [GW-1:0]     gap_cnt, gap_nxt;

  assign full        = (count == (PW+1)'(DEPTH));
  assign empty       = (count == '0);
  assign o_req_ready = ~full;
  assign push        = i_req_valid & ~full;
  assign pop         = (state == IDLE) & ~empty;
  assign o_busy      = ~empty | (state != IDLE);

  // Storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge i_ck) begin
    if (push) begin
      fifo_rw[wr_ptr]    <= i_req_rw;
      fifo_addr[wr_ptr]  <= i_req_addr;
      fifo_wdata[wr_ptr] <= i_req_wdata;
    end
  end

  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      o_csn       <= 1'b1;
      o_rw        <= 1'b1;
      o_address   <= '0;
      o_data      <= '0;
      o_data_oe   <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      o_csn       <= csn_nxt;
      o_rw        <= rw_nxt;
      o_address   <= addr_nxt;
      o_data      <= data_nxt;
      o_data_oe   <= oe_nxt;
      o_rsp_valid <= rsp_valid_nxt;
      o_rsp_data  <= rsp_data_nxt;
      gap_cnt     <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    csn_nxt       = o_csn;
    rw_nxt        = o_rw;
    addr_nxt      = o_address;
    data_nxt      = o_data;
    oe_nxt        = o_data_oe;
    rsp_valid_nxt = 1'b0;
    rsp_data_nxt  = o_rsp_data;
    gap_nxt       = gap_cnt;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt = ACCESS;
          csn_nxt   = 1'b0;
          rw_nxt    = fifo_rw[rd_ptr];
          addr_nxt  = fifo_addr[rd_ptr];
          if (!fifo_rw[rd_ptr]) begin
            data_nxt = fifo_wdata[rd_ptr];
            oe_nxt   = 1'b1;
          end
        end
      end
      ACCESS: begin
        csn_nxt  = 1'b1;
        rw_nxt   = 1'b1;
        addr_nxt = '0;
        data_nxt = '0;
        oe_nxt   = 1'b0;
        // o_rw still holds the direction of the access now completing
        if (o_rw) begin
          rsp_valid_nxt = 1'b1;
          rsp_data_nxt  = i_data;
        end
        if (GAP_LEN > 0) begin
          state_nxt = GAP;
          gap_nxt   = GW'(GAP_LEN - 1);
        end else begin
          state_nxt = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
        else               gap_nxt   = gap_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire
